// File: rtl/tdm_demux4_if.sv
// Serial link and de-interleaved word bundle for the 4-channel TDM receiver.
// master = link/consumer side (bench), slave = tdm_demux4.
interface tdm_demux4_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_bit;
  logic             in_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic             out_valid;
  logic             locked;
  logic             sync_err;

  modport master (
    output in_bit, in_valid, frame_sync,
    input  out_a, out_b, out_c, out_d, out_valid, locked, sync_err
  );

  modport slave (
    input  in_bit, in_valid, frame_sync,
    output out_a, out_b, out_c, out_d, out_valid, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// Receive end of the 4-channel TDM link: de-interleaves one bit per slot (A/B/C/D)
// into four WIDTH-bit words and presents them together once per frame.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  tdm_demux4_if.slave  bus
);

  localparam int unsigned FRAME = 4 * WIDTH;
  localparam int unsigned PW    = $clog2(FRAME);

  typedef enum logic {HUNT, RUN} state_t;

  state_t           state, state_d;
  logic [PW-1:0]    pos, pos_d;
  logic [WIDTH-1:0] sh_a, sh_b, sh_c, sh_d;
  logic [WIDTH-1:0] sh_a_d, sh_b_d, sh_c_d, sh_d_d;
  logic [WIDTH-1:0] out_a_d, out_b_d, out_c_d, out_d_d;
  logic             out_valid_d, sync_err_d;
  logic             last_c;

  function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] r, input logic b);
    return {r[WIDTH-2:0], b};
  endfunction

  assign last_c = (pos == PW'(FRAME - 1));

  // Next-state, shift and word-load decode; nothing moves without in_valid.
  always_comb begin
    state_d     = state;
    pos_d       = pos;
    sh_a_d      = sh_a;
    sh_b_d      = sh_b;
    sh_c_d      = sh_c;
    sh_d_d      = sh_d;
    out_a_d     = bus.out_a;
    out_b_d     = bus.out_b;
    out_c_d     = bus.out_c;
    out_d_d     = bus.out_d;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;

    if (bus.in_valid) begin
      case (state)
        HUNT: begin
          if (bus.frame_sync) begin
            sh_a_d  = shl(sh_a, bus.in_bit);
            pos_d   = PW'(1);
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.frame_sync && (pos != '0)) begin
            // Early sync: drop the partial frame and restart on this beat.
            sync_err_d = 1'b1;
            sh_a_d     = shl(sh_a, bus.in_bit);
            pos_d      = PW'(1);
          end else if (!bus.frame_sync && (pos == '0)) begin
            sync_err_d = 1'b1;
            pos_d      = '0;
            state_d    = HUNT;
          end else begin
            case (pos[1:0])
              2'd0:    sh_a_d = shl(sh_a, bus.in_bit);
              2'd1:    sh_b_d = shl(sh_b, bus.in_bit);
              2'd2:    sh_c_d = shl(sh_c, bus.in_bit);
              default: sh_d_d = shl(sh_d, bus.in_bit);
            endcase
            if (last_c) begin
              out_a_d     = sh_a;
              out_b_d     = sh_b;
              out_c_d     = sh_c;
              out_d_d     = shl(sh_d, bus.in_bit);
              out_valid_d = 1'b1;
              pos_d       = '0;
            end else begin
              pos_d = pos + PW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= HUNT;
      pos           <= '0;
      sh_a          <= '0;
      sh_b          <= '0;
      sh_c          <= '0;
      sh_d          <= '0;
      bus.out_a     <= '0;
      bus.out_b     <= '0;
      bus.out_c     <= '0;
      bus.out_d     <= '0;
      bus.out_valid <= 1'b0;
      bus.sync_err  <= 1'b0;
      bus.locked    <= 1'b0;
    end else begin
      state         <= state_d;
      pos           <= pos_d;
      sh_a          <= sh_a_d;
      sh_b          <= sh_b_d;
      sh_c          <= sh_c_d;
      sh_d          <= sh_d_d;
      bus.out_a     <= out_a_d;
      bus.out_b     <= out_b_d;
      bus.out_c     <= out_c_d;
      bus.out_d     <= out_d_d;
      bus.out_valid <= out_valid_d;
      bus.sync_err  <= sync_err_d;
      bus.locked    <= (state_d == RUN);
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WIDTH=8): clean frames, stalls, back-to-back,
// resync, loss of lock and asynchronous reset.
module tb_tdm_demux4;

  localparam int unsigned W = 8;

  localparam logic [31:0] F1 = {8'hA5, 8'h3C, 8'hFF, 8'h01};
  localparam logic [31:0] F2 = {8'h11, 8'h22, 8'h33, 8'h44};
  localparam logic [31:0] F3 = {8'h5A, 8'hC3, 8'h0F, 8'hF0};

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  int   vcnt = 0;
  int   ecnt = 0;
  int   cyc = 0;

  tdm_demux4_if #(.WIDTH(W)) bus ();

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid) vcnt <= vcnt + 1;
    if (bus.sync_err)  ecnt <= ecnt + 1;
  end

  function automatic logic fbit(input logic [31:0] w, input int k);
    logic [7:0] word;
    word = w[(3 - (k % 4)) * 8 +: 8];
    return word[3'(7 - (k / 4))];
  endfunction

  task automatic beat(input logic b, input logic fs);
    bus.in_valid   = 1'b1;
    bus.in_bit     = b;
    bus.frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid   = 1'b0;
    bus.in_bit     = 1'b0;
    bus.frame_sync = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input logic [31:0] w, input int from, input int to);
    for (int k = from; k <= to; k++) beat(fbit(w, k), (k == 0));
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_bit     = 1'b0;
    bus.frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== 32'h0) begin
      errors++;
      $display("FAIL reset_words got=%h exp=%h", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, 32'h0);
    end
    checks++;
    if ({bus.out_valid, bus.locked, bus.sync_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000", {bus.out_valid, bus.locked, bus.sync_err});
    end
  endtask

  task automatic test_clean_frame();
    int st;
    int v0;
    do_reset();
    v0 = vcnt;
    st = cyc;
    send_beats(F1, 0, 0);
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL clean_locked got=%b exp=1", bus.locked);
    end
    send_beats(F1, 1, 30);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_early_valid got=%b exp=0", bus.out_valid);
    end
    send_beats(F1, 31, 31);
    checks++;
    if (bus.out_valid !== 1'b1 || (cyc - st) != 32) begin
      errors++;
      $display("FAIL clean_valid got=%b cycles=%0d exp=1 cycles=32", bus.out_valid, cyc - st);
    end
    checks++;
    if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== F1) begin
      errors++;
      $display("FAIL clean_words got=%h exp=%h", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, F1);
    end
    idle(2);
    checks++;
    if (bus.out_valid !== 1'b0 || (vcnt - v0) != 1) begin
      errors++;
      $display("FAIL clean_pulse_once got=%b pulses=%0d exp=0 pulses=1", bus.out_valid, vcnt - v0);
    end
  endtask

  task automatic test_stall();
    int st;
    do_reset();
    st = cyc;
    send_beats(F1, 0, 4);
    idle(3);
    send_beats(F1, 5, 16);
    idle(3);
    send_beats(F1, 17, 30);
    idle(3);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL stall_midframe got=%b%b exp=01", bus.out_valid, bus.locked);
    end
    send_beats(F1, 31, 31);
    checks++;
    if (bus.out_valid !== 1'b1 || (cyc - st) != 41) begin
      errors++;
      $display("FAIL stall_valid got=%b cycles=%0d exp=1 cycles=41", bus.out_valid, cyc - st);
    end
    checks++;
    if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== F1) begin
      errors++;
      $display("FAIL stall_words got=%h exp=%h", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, F1);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    do_reset();
    v0 = vcnt;
    send_beats(F1, 0, 31);
    send_beats(F2, 0, 15);
    checks++;
    if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== F1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold got=%h v=%b exp=%h v=0", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, bus.out_valid, F1);
    end
    send_beats(F2, 16, 31);
    checks++;
    if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== F2 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got=%h v=%b exp=%h v=1", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, bus.out_valid, F2);
    end
    idle(2);
    checks++;
    if ((vcnt - v0) != 2) begin
      errors++;
      $display("FAIL b2b_pulses got=%0d exp=2", vcnt - v0);
    end
  endtask

  task automatic test_resync();
    int v0;
    int e0;
    do_reset();
    send_beats(F1, 0, 31);
    idle(2);
    v0 = vcnt;
    e0 = ecnt;
    send_beats(F2, 0, 11);
    send_beats(F3, 0, 0);
    checks++;
    if (bus.sync_err !== 1'b1 || bus.out_valid !== 1'b0 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL resync_err got=%b%b%b exp=101", bus.sync_err, bus.out_valid, bus.locked);
    end
    checks++;
    if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== F1) begin
      errors++;
      $display("FAIL resync_hold got=%h exp=%h", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, F1);
    end
    send_beats(F3, 1, 31);
    checks++;
    if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== F3 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL resync_words got=%h v=%b exp=%h v=1", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, bus.out_valid, F3);
    end
    idle(2);
    checks++;
    if ((vcnt - v0) != 1 || (ecnt - e0) != 1) begin
      errors++;
      $display("FAIL resync_counts got=v%0d e%0d exp=v1 e1", vcnt - v0, ecnt - e0);
    end
  endtask

  task automatic test_unlock();
    int v0;
    int e0;
    do_reset();
    send_beats(F1, 0, 31);
    idle(2);
    v0 = vcnt;
    e0 = ecnt;
    beat(1'b1, 1'b0);
    checks++;
    if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL unlock_err got=%b%b%b exp=100", bus.sync_err, bus.locked, bus.out_valid);
    end
    for (int k = 0; k < 5; k++) beat(k[0], 1'b0);
    idle(2);
    checks++;
    if (bus.locked !== 1'b0 || (ecnt - e0) != 1 || (vcnt - v0) != 0) begin
      errors++;
      $display("FAIL unlock_hunt got=l%b e%0d v%0d exp=l0 e1 v0", bus.locked, ecnt - e0, vcnt - v0);
    end
    checks++;
    if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== F1) begin
      errors++;
      $display("FAIL unlock_hold got=%h exp=%h", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, F1);
    end
    send_beats(F2, 0, 0);
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL unlock_relock got=%b exp=1", bus.locked);
    end
    send_beats(F2, 1, 31);
    checks++;
    if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== F2 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL unlock_words got=%h v=%b exp=%h v=1", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, bus.out_valid, F2);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_beats(F1, 0, 31);
    send_beats(F2, 0, 19);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== 32'h0 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL areset_clear got=%h l=%b exp=%h l=0", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, bus.locked, 32'h0);
    end
    idle(1);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_beats(F3, 0, 31);
    checks++;
    if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== F3 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_frame got=%h v=%b exp=%h v=1", {bus.out_a, bus.out_b, bus.out_c, bus.out_d}, bus.out_valid, F3);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_bit     = 1'b0;
    bus.frame_sync = 1'b0;
    test_reset();
    test_clean_frame();
    test_stall();
    test_back_to_back();
    test_resync();
    test_unlock();
    test_async_reset();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
